// File: rtl/vec_pkg.sv
// Shared types and defaults for the vector execution sequencer.
package vec_pkg;

   localparam int VLEN_ELEMS_DEF = 8;
   localparam int ELEN_DEF       = 32;

   typedef enum logic [2:0] {
      OP_NONE,
      OP_VXOR,
      OP_VMACC,
      OP_VREDSUM,
      OP_VSLIDEUP,
      OP_VRGATHER
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_GRD,
      ST_EX,
      ST_FIN
   } state_e;

   // Anything other than exactly one decoded op bit is treated as illegal.
   function automatic op_e decode_op(input logic [4:0] hot);
      op_e op;
      case (hot)
         5'b00001: op = OP_VXOR;
         5'b00010: op = OP_VMACC;
         5'b00100: op = OP_VREDSUM;
         5'b01000: op = OP_VSLIDEUP;
         5'b10000: op = OP_VRGATHER;
         default:  op = OP_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/vector_alu.sv
// Combinational per-element datapath: xor, multiply-add, reduction add,
// pass-through for slides and zero-select for out-of-range gathers.
module vector_alu
   import vec_pkg::*;
#(
   parameter int ELEN = ELEN_DEF
) (
   input  op_e             op_i,
   input  logic [ELEN-1:0] ra_i,
   input  logic [ELEN-1:0] rb_i,
   input  logic [ELEN-1:0] rc_i,
   input  logic [ELEN-1:0] acc_i,
   input  logic            first_i,
   input  logic            zero_i,
   output logic [ELEN-1:0] res_o,
   output logic [ELEN-1:0] acc_o
);

   logic [ELEN-1:0] prod;

   assign prod  = ra_i * rb_i;
   assign acc_o = acc_i + rb_i + (first_i ? ra_i : '0);

   // Element result selected by the captured op.
   always_comb begin
      res_o = '0;
      case (op_i)
         OP_VXOR:     res_o = rb_i ^ ra_i;
         OP_VMACC:    res_o = prod + rc_i;
         OP_VSLIDEUP: res_o = rb_i;
         OP_VRGATHER: res_o = zero_i ? '0 : rb_i;
         default:     res_o = '0;
      endcase
   end

endmodule

// File: rtl/vector_sequencer.sv
// Element-serial execution sequencer between the vector decoder and the VRF.
//
// state   | meaning
// IDLE    | ready for a new instruction
// RD      | present VRF read addresses for element i
// GRD     | vrgather: use index from vs1[i] to address vs2
// EX      | read data valid; compute, write vd[i] (or accumulate), advance i
// FIN     | one-cycle done pulse; vredsum writes its sum to vd[0]
module vector_sequencer
   import vec_pkg::*;
#(
   parameter int VLEN_ELEMS = VLEN_ELEMS_DEF,
   parameter int ELEN       = ELEN_DEF,
   parameter int EIDX_W     = $clog2(VLEN_ELEMS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vsi_valid,
   output logic              vsi_ready,
   input  logic [4:0]        vd,
   input  logic [4:0]        vs1,
   input  logic [4:0]        vs2,
   input  logic [4:0]        uimm,
   input  logic              is_vxor,
   input  logic              is_vmacc,
   input  logic              is_vredsum,
   input  logic              is_vslideup,
   input  logic              is_vrgather,
   output logic [4:0]        vrf_ra_reg,
   output logic [4:0]        vrf_rb_reg,
   output logic [4:0]        vrf_rc_reg,
   output logic [EIDX_W-1:0] vrf_ra_elem,
   output logic [EIDX_W-1:0] vrf_rb_elem,
   output logic [EIDX_W-1:0] vrf_rc_elem,
   input  logic [ELEN-1:0]   vrf_ra_data,
   input  logic [ELEN-1:0]   vrf_rb_data,
   input  logic [ELEN-1:0]   vrf_rc_data,
   output logic              vrf_we,
   output logic [4:0]        vrf_wa_reg,
   output logic [EIDX_W-1:0] vrf_wa_elem,
   output logic [ELEN-1:0]   vrf_wdata,
   output logic              vsi_done,
   output logic              vsi_illegal,
   output logic              busy
);

   localparam logic [EIDX_W-1:0] LAST_ELEM = EIDX_W'(VLEN_ELEMS - 1);
   localparam logic [ELEN-1:0]   NELEM_E   = ELEN'(VLEN_ELEMS);

   state_e            state_q, state_d;
   op_e               op_q, op_d, op_in;
   logic [4:0]        vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d, uimm_q, uimm_d;
   logic [EIDX_W-1:0] i_q, i_d;
   logic [ELEN-1:0]   acc_q, acc_d;
   logic              oor_q, oor_d;
   logic [ELEN-1:0]   alu_res, alu_acc;

   assign op_in     = decode_op({is_vrgather, is_vslideup, is_vredsum, is_vmacc, is_vxor});
   assign vsi_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);

   vector_alu #(.ELEN(ELEN)) u_alu (
      .op_i    (op_q),
      .ra_i    (vrf_ra_data),
      .rb_i    (vrf_rb_data),
      .rc_i    (vrf_rc_data),
      .acc_i   (acc_q),
      .first_i (i_q == '0),
      .zero_i  (oor_q),
      .res_o   (alu_res),
      .acc_o   (alu_acc)
   );

   // Next-state, counter/accumulator update and VRF port drive.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      vd_d        = vd_q;
      vs1_d       = vs1_q;
      vs2_d       = vs2_q;
      uimm_d      = uimm_q;
      i_d         = i_q;
      acc_d       = acc_q;
      oor_d       = oor_q;
      vrf_we      = 1'b0;
      vrf_wa_reg  = vd_q;
      vrf_wa_elem = i_q;
      vrf_wdata   = alu_res;
      vsi_done    = 1'b0;
      vsi_illegal = 1'b0;
      vrf_ra_reg  = vs1_q;
      vrf_ra_elem = (op_q == OP_VREDSUM) ? '0 : i_q;
      vrf_rb_reg  = vs2_q;
      vrf_rb_elem = (op_q == OP_VSLIDEUP) ? (i_q - EIDX_W'(uimm_q)) : i_q;
      vrf_rc_reg  = vd_q;
      vrf_rc_elem = i_q;
      case (state_q)
         ST_IDLE: begin
            if (vsi_valid) begin
               op_d   = op_in;
               vd_d   = vd;
               vs1_d  = vs1;
               vs2_d  = vs2;
               uimm_d = uimm;
               i_d    = '0;
               acc_d  = '0;
               oor_d  = 1'b0;
               if (op_in == OP_NONE) begin
                  state_d = ST_FIN;
               end else if (op_in == OP_VSLIDEUP) begin
                  if (int'(uimm) >= VLEN_ELEMS) begin
                     state_d = ST_FIN;
                  end else begin
                     i_d     = EIDX_W'(uimm);
                     state_d = ST_RD;
                  end
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_RD: begin
            state_d = (op_q == OP_VRGATHER) ? ST_GRD : ST_EX;
         end
         ST_GRD: begin
            vrf_rb_elem = vrf_ra_data[EIDX_W-1:0];
            oor_d       = (vrf_ra_data >= NELEM_E);
            state_d     = ST_EX;
         end
         ST_EX: begin
            if (op_q == OP_VREDSUM) begin
               acc_d = alu_acc;
            end else begin
               vrf_we = 1'b1;
            end
            i_d     = i_q + EIDX_W'(1);
            state_d = (i_q == LAST_ELEM) ? ST_FIN : ST_RD;
         end
         ST_FIN: begin
            vsi_done    = 1'b1;
            vsi_illegal = (op_q == OP_NONE);
            if (op_q == OP_VREDSUM) begin
               vrf_we      = 1'b1;
               vrf_wa_elem = '0;
               vrf_wdata   = acc_q;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // A reset cycle must never commit a write or signal completion.
      if (rst) begin
         vrf_we      = 1'b0;
         vsi_done    = 1'b0;
         vsi_illegal = 1'b0;
      end
   end

   // State, captured instruction, element counter and accumulator registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NONE;
         vd_q    <= '0;
         vs1_q   <= '0;
         vs2_q   <= '0;
         uimm_q  <= '0;
         i_q     <= '0;
         acc_q   <= '0;
         oor_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         vd_q    <= vd_d;
         vs1_q   <= vs1_d;
         vs2_q   <= vs2_d;
         uimm_q  <= uimm_d;
         i_q     <= i_d;
         acc_q   <= acc_d;
         oor_q   <= oor_d;
      end
   end

endmodule

// File: tb/tb_vector_sequencer.sv
// Scoreboard bench for vector_sequencer: a VRF model serves reads, a reference
// model predicts every write and done pulse, a monitor compares them.
module tb_vector_sequencer;
   import vec_pkg::*;

   localparam int N  = 8;
   localparam int EL = 32;
   localparam int EW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          vsi_valid, vsi_ready;
   logic [4:0]    vd, vs1, vs2, uimm;
   logic          is_vxor, is_vmacc, is_vredsum, is_vslideup, is_vrgather;
   logic [4:0]    vrf_ra_reg, vrf_rb_reg, vrf_rc_reg;
   logic [EW-1:0] vrf_ra_elem, vrf_rb_elem, vrf_rc_elem;
   logic [EL-1:0] vrf_ra_data, vrf_rb_data, vrf_rc_data;
   logic          vrf_we;
   logic [4:0]    vrf_wa_reg;
   logic [EW-1:0] vrf_wa_elem;
   logic [EL-1:0] vrf_wdata;
   logic          vsi_done, vsi_illegal, busy;

   always #5 clk = ~clk;

   vector_sequencer #(.VLEN_ELEMS(N), .ELEN(EL), .EIDX_W(EW)) dut (
      .clk(clk), .rst(rst), .vsi_valid(vsi_valid), .vsi_ready(vsi_ready),
      .vd(vd), .vs1(vs1), .vs2(vs2), .uimm(uimm),
      .is_vxor(is_vxor), .is_vmacc(is_vmacc), .is_vredsum(is_vredsum),
      .is_vslideup(is_vslideup), .is_vrgather(is_vrgather),
      .vrf_ra_reg(vrf_ra_reg), .vrf_rb_reg(vrf_rb_reg), .vrf_rc_reg(vrf_rc_reg),
      .vrf_ra_elem(vrf_ra_elem), .vrf_rb_elem(vrf_rb_elem), .vrf_rc_elem(vrf_rc_elem),
      .vrf_ra_data(vrf_ra_data), .vrf_rb_data(vrf_rb_data), .vrf_rc_data(vrf_rc_data),
      .vrf_we(vrf_we), .vrf_wa_reg(vrf_wa_reg), .vrf_wa_elem(vrf_wa_elem),
      .vrf_wdata(vrf_wdata), .vsi_done(vsi_done), .vsi_illegal(vsi_illegal),
      .busy(busy)
   );

   // VRF model: one-cycle read latency, DUT writes, and bench preloads.
   logic [31:0] vrf [32][N];
   logic        pl_en;
   logic [4:0]  pl_reg;
   logic [31:0] pl_vec [N];
   int          cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pl_en) for (int e = 0; e < N; e++) vrf[pl_reg][e] <= pl_vec[e];
      if (vrf_we) vrf[vrf_wa_reg][vrf_wa_elem] <= vrf_wdata;
      vrf_ra_data <= vrf[vrf_ra_reg][vrf_ra_elem];
      vrf_rb_data <= vrf[vrf_rb_reg][vrf_rb_elem];
      vrf_rc_data <= vrf[vrf_rc_reg][vrf_rc_elem];
   end

   typedef struct {
      logic [4:0]  r;
      logic [2:0]  e;
      logic [31:0] d;
      int          c;
   } wr_t;
   typedef struct {
      logic ill;
      int   c;
   } dn_t;

   wr_t wq[$];
   dn_t dq[$];
   int  checks = 0;
   int  errors = 0;

   // Monitor: every write and done pulse must match the head of its queue.
   always @(negedge clk) begin
      wr_t w;
      dn_t d;
      if (!rst) begin
         if (vrf_we) begin
            checks++;
            if (wq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write got reg=%0d elem=%0d data=%h cyc=%0d, required no write",
                        vrf_wa_reg, vrf_wa_elem, vrf_wdata, cyc);
            end else begin
               w = wq.pop_front();
               if (vrf_wa_reg !== w.r || vrf_wa_elem !== w.e || vrf_wdata !== w.d || cyc != w.c) begin
                  errors++;
                  $display("FAIL vrf_write got reg=%0d elem=%0d data=%h cyc=%0d, required reg=%0d elem=%0d data=%h cyc=%0d",
                           vrf_wa_reg, vrf_wa_elem, vrf_wdata, cyc, w.r, w.e, w.d, w.c);
               end
            end
         end
         if (vsi_done) begin
            checks++;
            if (dq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done got illegal=%0b cyc=%0d, required no done", vsi_illegal, cyc);
            end else begin
               d = dq.pop_front();
               if (vsi_illegal !== d.ill || cyc != d.c) begin
                  errors++;
                  $display("FAIL done got illegal=%0b cyc=%0d, required illegal=%0b cyc=%0d",
                           vsi_illegal, cyc, d.ill, d.c);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h, required %h", nm, got, exp);
      end
   endtask

   task automatic push_wr(input int r, input int e, input logic [31:0] d, input int c);
      wr_t w;
      w.r = 5'(r);
      w.e = 3'(e);
      w.d = d;
      w.c = c;
      wq.push_back(w);
   endtask

   task automatic push_dn(input logic ill, input int c);
      dn_t d;
      d.ill = ill;
      d.c   = c;
      dq.push_back(d);
   endtask

   // Reference model: predicted writes and done timing from the VRF contents
   // at the moment of acceptance in cycle t.
   task automatic model(input op_e op, input int rd, input int r1, input int r2, input int u, input int t);
      logic [31:0] s, idx;
      case (op)
         OP_VXOR: begin
            for (int i = 0; i < N; i++) push_wr(rd, i, vrf[r2][i] ^ vrf[r1][i], t + 2*(i+1));
            push_dn(1'b0, t + 2*N + 1);
         end
         OP_VMACC: begin
            for (int i = 0; i < N; i++) begin
               s = vrf[r1][i] * vrf[r2][i] + vrf[rd][i];
               push_wr(rd, i, s, t + 2*(i+1));
            end
            push_dn(1'b0, t + 2*N + 1);
         end
         OP_VREDSUM: begin
            s = vrf[r1][0];
            for (int i = 0; i < N; i++) s = s + vrf[r2][i];
            push_wr(rd, 0, s, t + 2*N + 1);
            push_dn(1'b0, t + 2*N + 1);
         end
         OP_VSLIDEUP: begin
            if (u >= N) begin
               push_dn(1'b0, t + 1);
            end else begin
               for (int i = u; i < N; i++) push_wr(rd, i, vrf[r2][i-u], t + 2*(i-u+1));
               push_dn(1'b0, t + 2*(N-u) + 1);
            end
         end
         OP_VRGATHER: begin
            for (int i = 0; i < N; i++) begin
               idx = vrf[r1][i];
               s = (idx < N) ? vrf[r2][int'(idx)] : 32'h0;
               push_wr(rd, i, s, t + 3*(i+1));
            end
            push_dn(1'b0, t + 3*N + 1);
         end
         default: push_dn(1'b1, t + 1);
      endcase
   endtask

   task automatic load(input int r);
      pl_reg = 5'(r);
      pl_en  = 1'b1;
      @(negedge clk);
      pl_en  = 1'b0;
   endtask

   task automatic fill(input int r, input logic [31:0] v);
      for (int e = 0; e < N; e++) pl_vec[e] = v;
      load(r);
   endtask

   task automatic issue(input op_e op, input int rd, input int r1, input int r2, input int u);
      int n = 0;
      while (!vsi_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!vsi_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout got ready=0, required ready=1");
         return;
      end
      vd = 5'(rd); vs1 = 5'(r1); vs2 = 5'(r2); uimm = 5'(u);
      is_vxor     = (op == OP_VXOR);
      is_vmacc    = (op == OP_VMACC);
      is_vredsum  = (op == OP_VREDSUM);
      is_vslideup = (op == OP_VSLIDEUP);
      is_vrgather = (op == OP_VRGATHER);
      vsi_valid   = 1'b1;
      model(op, rd, r1, r2, u, cyc);
      @(negedge clk);
      vsi_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((wq.size() != 0 || dq.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (wq.size() != 0 || dq.size() != 0) begin
         errors++;
         $display("FAIL completion_timeout got %0d writes and %0d dones outstanding, required 0",
                  wq.size(), dq.size());
      end
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got no finish, required finish");
      $fatal(1);
   end

   initial begin
      int rd, r1, r2, u, opsel;
      op_e op;
      logic [31:0] gat [N];
      rst = 1'b1; vsi_valid = 1'b0; pl_en = 1'b0; pl_reg = '0;
      vd = '0; vs1 = '0; vs2 = '0; uimm = '0;
      is_vxor = 0; is_vmacc = 0; is_vredsum = 0; is_vslideup = 0; is_vrgather = 0;
      @(negedge clk);
      for (int r = 0; r < 32; r++) fill(r, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_ready", 32'(vsi_ready), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_we", 32'(vrf_we), 32'd0);
      chk("reset_done", 32'(vsi_done), 32'd0);
      chk("reset_illegal", 32'(vsi_illegal), 32'd0);

      // vxor
      fill(1, 32'hFFFF0000);
      fill(2, 32'h0F0F0F0F);
      issue(OP_VXOR, 3, 1, 2, 0);
      wait_idle();
      for (int e = 0; e < N; e++) chk("vxor_result", vrf[3][e], 32'hF0F00F0F);

      // vmacc with wrap, then with a product overflowing ELEN
      for (int e = 0; e < N; e++) pl_vec[e] = 32'(e + 1);
      load(1);
      fill(2, 32'd2);
      fill(3, 32'hFFFFFFFF);
      issue(OP_VMACC, 3, 1, 2, 0);
      wait_idle();
      for (int e = 0; e < N; e++) chk("vmacc_wrap", vrf[3][e], 32'(2*e + 1));
      fill(1, 32'h00010000);
      fill(2, 32'h00010000);
      fill(3, 32'd7);
      issue(OP_VMACC, 3, 1, 2, 0);
      wait_idle();
      chk("vmacc_ovf", vrf[3][5], 32'd7);

      // vredsum
      fill(1, 32'd5);
      for (int e = 0; e < N; e++) pl_vec[e] = 32'(e);
      load(2);
      fill(4, 32'h0);
      issue(OP_VREDSUM, 4, 1, 2, 0);
      wait_idle();
      chk("vredsum_sum", vrf[4][0], 32'd33);
      chk("vredsum_elem1", vrf[4][1], 32'd0);

      // vslideup in range and past the end
      fill(5, 32'h55);
      for (int e = 0; e < N; e++) pl_vec[e] = 32'(32'hA0 + e);
      load(2);
      issue(OP_VSLIDEUP, 5, 0, 2, 3);
      wait_idle();
      for (int e = 0; e < 3; e++) chk("vslideup_below", vrf[5][e], 32'h55);
      for (int e = 3; e < N; e++) chk("vslideup_moved", vrf[5][e], 32'(32'hA0 + e - 3));
      issue(OP_VSLIDEUP, 5, 0, 2, 9);
      wait_idle();

      // vrgather with out-of-range indices
      gat = '{32'd7, 32'd0, 32'd9, 32'd2, 32'd5, 32'd8, 32'd1, 32'd3};
      for (int e = 0; e < N; e++) pl_vec[e] = gat[e];
      load(1);
      for (int e = 0; e < N; e++) pl_vec[e] = 32'(32'hB0 + e);
      load(2);
      issue(OP_VRGATHER, 6, 1, 2, 0);
      wait_idle();
      chk("vrgather_e0", vrf[6][0], 32'hB7);
      chk("vrgather_e2", vrf[6][2], 32'h0);
      chk("vrgather_e5", vrf[6][5], 32'h0);

      // illegal
      issue(OP_NONE, 7, 1, 2, 0);
      wait_idle();

      // reset in the middle of a vxor
      issue(OP_VXOR, 8, 1, 2, 0);
      repeat (4) @(negedge clk);
      wq.delete();
      dq.delete();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midreset_ready", 32'(vsi_ready), 32'd1);
      chk("midreset_busy", 32'(busy), 32'd0);
      repeat (20) @(negedge clk);

      // randomized instructions
      for (int k = 0; k < 40; k++) begin
         opsel = $urandom_range(0, 5);
         op = op_e'(opsel[2:0]);
         u = (op == OP_VSLIDEUP) ? $urandom_range(0, 10) : 0;
         do begin
            rd = $urandom_range(0, 31);
            r1 = $urandom_range(0, 31);
            r2 = $urandom_range(0, 31);
         end while ((op == OP_VSLIDEUP && rd == r2) ||
                    (op == OP_VRGATHER && (rd == r1 || rd == r2)));
         for (int e = 0; e < N; e++) pl_vec[e] = $urandom;
         load(rd);
         for (int e = 0; e < N; e++)
            pl_vec[e] = (op == OP_VRGATHER) ? 32'($urandom_range(0, 11)) : $urandom;
         load(r1);
         if (!(op == OP_VRGATHER && r1 == r2)) begin
            for (int e = 0; e < N; e++) pl_vec[e] = $urandom;
            load(r2);
         end
         issue(op, rd, r1, r2, u);
         wait_idle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
- Execution sequencer directly downstream of the vector instruction decoder.
- Accepts one decoded vector instruction per valid/ready handshake and walks its elements one at a time.
- Drives three element-granular read ports and one write port of the vector register file (VRF).
- Pulses done on completion; non-pipelined, one instruction in flight.

Parameters:
- VLEN_ELEMS, 8, elements per vector register (power of two, >=2).
- ELEN, 32, element width in bits.
- EIDX_W, $clog2(VLEN_ELEMS), element index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- vsi_valid  in  1  decoded instruction available
- vsi_ready  out  1  sequencer can accept
- vd, vs1, vs2, uimm  in  5 each  decoded operand fields
- is_vxor, is_vmacc, is_vredsum, is_vslideup, is_vrgather  in  1 each  one-hot decoded op (all zero = illegal)
- vrf_ra_reg/vrf_rb_reg/vrf_rc_reg  out  5  read register numbers
- vrf_ra_elem/vrf_rb_elem/vrf_rc_elem  out  EIDX_W  read element indices
- vrf_ra_data/vrf_rb_data/vrf_rc_data  in  ELEN  read data, valid one cycle after address
- vrf_we  out  1  write enable
- vrf_wa_reg  out  5 ; vrf_wa_elem  out  EIDX_W ; vrf_wdata  out  ELEN
- vsi_done  out  1  one-cycle completion pulse
- vsi_illegal  out  1  qualifies vsi_done: instruction was illegal
- busy  out  1  high in any state except IDLE

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst, as the codebase names them.
- Reset: state IDLE; vsi_ready=1; vrf_we=0; vsi_done=0; vsi_illegal=0; busy=0; element counter, accumulator and captured fields cleared. Read addresses are don't-care.
- Accept when vsi_valid && vsi_ready, only in IDLE. Capture vd/vs1/vs2/uimm/op; vsi_ready=0 until return to IDLE.
- States: IDLE, RD, GRD, EX, FIN.
- IDLE -> RD on accept. Illegal op goes to FIN directly, no VRF writes.
- Element counter i starts at 0. For vslideup it starts at uimm; if uimm >= VLEN_ELEMS, go to FIN directly.
- RD: present read addresses for element i; next state is GRD for vrgather, EX otherwise.
- GRD (vrgather only): idx = vrf_ra_data. If idx < VLEN_ELEMS, present rb = vs2[idx]; otherwise mark element as zero. Next state EX.
- EX: read data valid. Compute and write (vrf_we=1, vrf_wa_reg=vd, vrf_wa_elem=i) except vredsum. Increment i; if i was VLEN_ELEMS-1 go to FIN, else RD.
- Per-op reads / result:
  - vxor: ra=vs1[i], rb=vs2[i]; vs2^vs1.
  - vmacc: ra=vs1[i], rb=vs2[i], rc=vd[i]; (vs1*vs2 + vd) mod 2^ELEN, low ELEN bits of product.
  - vredsum: ra=vs1[0], rb=vs2[i]. EX adds rb to acc, plus ra when i==0, mod 2^ELEN. No write in EX.
  - vslideup: rb=vs2[i-uimm]; writes vd[i] for uimm <= i < VLEN_ELEMS. Elements below uimm are untouched.
  - vrgather: ra=vs1[i] in RD; result vs2[idx], or 0 if out of range.
- FIN: vsi_done=1 for one cycle; vsi_illegal=1 if illegal. For vredsum, vrf_we=1 in FIN writing acc to vd[0]. Next state IDLE, vsi_ready=1 next cycle.
- Latency (accept in cycle T, done in cycle D):
  - vxor/vmacc/vredsum: D = T + 2*VLEN_ELEMS + 1.
  - vrgather: D = T + 3*VLEN_ELEMS + 1.
  - vslideup: D = T + 2*(VLEN_ELEMS-uimm) + 1.
  - illegal: D = T + 1.
- Register overlap (vd==vs2 for vslideup; vd==vs1 or vd==vs2 for vrgather) is an illegal program. Elements are processed ascending regardless; benches exclude these cases.
- rst asserted mid-instruction: next cycle IDLE, no further writes, no done pulse.
- vsi_valid while busy is ignored (ready low); the upstream stage holds the instruction.

Decomposition:
- Shared package vec_pkg: op enum (OP_NONE, OP_VXOR, OP_VMACC, OP_VREDSUM, OP_VSLIDEUP, OP_VRGATHER), state enum, VLEN_ELEMS/ELEN defaults.
- One natural sub-module, vector_alu: combinational element datapath (xor, mul-add, add, pass, zero-select).
- The FSM, counter and accumulator stay in vector_sequencer.

Test Plan:
- vxor vd=3, vs1=1 (all 0xFFFF0000), vs2=2 (all 0x0F0F0F0F) -> 8 writes of 0xF0F00F0F to v3 elems 0..7; done at T+17.
- vmacc with v1[i]=i+1, v2[i]=2, v3[i]=0xFFFFFFFF -> v3[i]=2i+1 (wrap); v1=0x10000, v2=0x10000 -> low bits 0.
- vredsum vs1[0]=5, v2[i]=i -> single write v_d[0]=33 in the FIN cycle alongside done; no other writes.
- vslideup uimm=3, v2[i]=0xA0+i -> v_d[3..7]=0xA0..0xA4, elems 0..2 unwritten, done at T+11. Also uimm=9 -> done at T+1, no writes.
- vrgather v1={7,0,9,2,...}, v2[i]=0xB0+i -> v_d={0xB7,0xB0,0,0xB2,...}; done at T+25.
- All is_* zero -> done and illegal pulse at T+1, no writes. Reset at T+5 of vxor -> no writes after reset, no done, ready high next cycle.
